// File: rtl/btn_multi_deb.sv
// N-channel push-button conditioner: two-flop synchroniser, debouncer, press/release
// pulses, long-press pulse and auto-repeat pulse per channel, all on one clock.
module btn_multi_deb #(
    parameter int N          = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DEB_MS     = 3,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] btn_state,
    output logic [N-1:0] btn_posedge,
    output logic [N-1:0] btn_negedge,
    output logic [N-1:0] btn_long,
    output logic [N-1:0] btn_repeat
);

    localparam int DEB_CNT    = CLK_HZ / 1000 * DEB_MS;
    localparam int LONG_CNT   = CLK_HZ / 1000 * LONG_MS;
    localparam int REPEAT_CNT = CLK_HZ / 1000 * REPEAT_MS;
    localparam int HOLD_MAX   = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int DW         = $clog2(DEB_CNT) + 1;
    localparam int HW         = $clog2((HOLD_MAX > 0) ? HOLD_MAX : 1) + 1;

    localparam logic [DW-1:0] DEB_TERM  = DW'(DEB_CNT - 1);
    localparam logic [HW-1:0] LONG_TERM = HW'((LONG_CNT > 0) ? LONG_CNT - 1 : 0);
    localparam logic [HW-1:0] REP_TERM  = HW'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);
    localparam logic [N-1:0]  POLARITY  = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } hold_state_t;

    logic [N-1:0] pin_pressed;

    // Polarity is corrected before the synchroniser so reset (0) always means released.
    assign pin_pressed = btn ^ POLARITY;

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic          sync1;
        logic          sync2;
        logic          level;
        logic          rise;
        logic          fall;
        logic          long_pulse;
        logic          rep_pulse;
        logic [DW-1:0] deb_cnt;
        logic          deb_done;
        logic          press;
        logic          release_evt;

        hold_state_t   state;
        hold_state_t   state_next;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_cnt_next;
        logic          long_next;
        logic          rep_next;

        assign deb_done    = (sync2 != level) && (deb_cnt == DEB_TERM);
        assign press       = deb_done && !level;
        assign release_evt = deb_done && level;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                level   <= 1'b0;
                deb_cnt <= '0;
                rise    <= 1'b0;
                fall    <= 1'b0;
            end else begin
                sync1 <= pin_pressed[i];
                sync2 <= sync1;
                rise  <= press;
                fall  <= release_evt;
                if (sync2 == level) begin
                    deb_cnt <= '0;
                end else if (deb_done) begin
                    level   <= ~level;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state      <= IDLE;
                hold_cnt   <= '0;
                long_pulse <= 1'b0;
                rep_pulse  <= 1'b0;
            end else begin
                state      <= state_next;
                hold_cnt   <= hold_cnt_next;
                long_pulse <= long_next;
                rep_pulse  <= rep_next;
            end
        end

        // A release on the same edge as a long/repeat terminal count suppresses that pulse.
        always_comb begin
            state_next    = state;
            hold_cnt_next = hold_cnt;
            long_next     = 1'b0;
            rep_next      = 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state_next    = HOLD;
                        hold_cnt_next = '0;
                    end
                end
                HOLD: begin
                    if (LONG_CNT != 0) begin
                        if (hold_cnt == LONG_TERM) begin
                            long_next     = 1'b1;
                            hold_cnt_next = '0;
                            state_next    = REPEAT;
                        end else begin
                            hold_cnt_next = hold_cnt + HW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (REPEAT_CNT != 0) begin
                        if (hold_cnt == REP_TERM) begin
                            rep_next      = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
            if (release_evt) begin
                state_next    = IDLE;
                hold_cnt_next = '0;
                long_next     = 1'b0;
                rep_next      = 1'b0;
            end
        end

        assign btn_state[i]   = level;
        assign btn_posedge[i] = rise;
        assign btn_negedge[i] = fall;
        assign btn_long[i]    = long_pulse;
        assign btn_repeat[i]  = rep_pulse;
    end

endmodule

// File: tb/tb_btn_multi_deb.sv
// Directed bench for btn_multi_deb: one active-high and one active-low instance
// at 1 cycle per ms (debounce 4, long 20, repeat 5).
module tb_btn_multi_deb;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] btn_state, btn_posedge, btn_negedge, btn_long, btn_repeat;
    logic [3:0] al_btn;
    logic [3:0] al_state, al_posedge, al_negedge, al_long, al_repeat;

    int checks;
    int passes;
    int pos_cnt[4];
    int neg_cnt[4];
    int long_cnt[4];
    int rep_cnt[4];
    int al_pulses;
    int violations;

    btn_multi_deb #(
        .N(4), .CLK_HZ(1000), .DEB_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_state(btn_state), .btn_posedge(btn_posedge), .btn_negedge(btn_negedge),
        .btn_long(btn_long), .btn_repeat(btn_repeat)
    );

    btn_multi_deb #(
        .N(4), .CLK_HZ(1000), .DEB_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .btn(al_btn),
        .btn_state(al_state), .btn_posedge(al_posedge), .btn_negedge(al_negedge),
        .btn_long(al_long), .btn_repeat(al_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            passes++;
    endtask

    // One clock edge, then sample outputs 1 time unit later and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (btn_posedge[i]) pos_cnt[i]++;
            if (btn_negedge[i]) neg_cnt[i]++;
            if (btn_long[i])    long_cnt[i]++;
            if (btn_repeat[i])  rep_cnt[i]++;
            if (btn_posedge[i] && btn_negedge[i]) violations++;
            if ((btn_long[i] || btn_repeat[i]) && (!btn_state[i] || btn_negedge[i])) violations++;
        end
        al_pulses += $countones({al_posedge, al_negedge, al_long, al_repeat});
    endtask

    task automatic applyStimulus(input logic [3:0] pins, input logic [3:0] al_pins, input int cycles);
        btn    = pins;
        al_btn = al_pins;
        repeat (cycles) tick();
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) begin
            pos_cnt[i]  = 0;
            neg_cnt[i]  = 0;
            long_cnt[i] = 0;
            rep_cnt[i]  = 0;
        end
        al_pulses = 0;
    endtask

    logic [3:0] bounce_seq [7];

    initial begin
        checks     = 0;
        passes     = 0;
        violations = 0;
        clearCounts();
        rst    = 1'b0;
        btn    = 4'b1111;
        al_btn = 4'b1111;

        // Reset with press held on every active-high channel
        applyStimulus(4'b1111, 4'b1111, 3);
        checkOutput("reset_outputs",
                    {btn_state, btn_posedge, btn_negedge, btn_long, btn_repeat,
                     al_state, al_posedge, al_negedge, al_long, al_repeat}, 64'h0);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 5);
        checkOutput("reset_rel_no_early_pos", {60'h0, btn_posedge}, 64'h0);
        tick();
        checkOutput("reset_rel_pos", {56'h0, btn_state, btn_posedge}, 64'hFF);
        checkOutput("reset_rel_no_neg", {neg_cnt[0], neg_cnt[1]} | {neg_cnt[2], neg_cnt[3]}, 64'h0);
        tick();
        checkOutput("reset_rel_pos_width", {60'h0, btn_posedge}, 64'h0);
        applyStimulus(4'b0000, 4'b1111, 12);
        checkOutput("reset_rel_release", {56'h0, btn_state, 4'(neg_cnt[0] + neg_cnt[1] + neg_cnt[2] + neg_cnt[3])}, 64'h04);
        clearCounts();

        // Clean press on ch0
        applyStimulus(4'b0001, 4'b1111, 5);
        checkOutput("clean_pre_state", {60'h0, btn_state}, 64'h0);
        tick();
        checkOutput("clean_pos", {56'h0, btn_state, btn_posedge}, 64'h11);
        tick();
        checkOutput("clean_pos_width", {56'h0, btn_state, btn_posedge}, 64'h10);
        applyStimulus(4'b0000, 4'b1111, 10);
        checkOutput("clean_counts", {32'(pos_cnt[0] * 16 + neg_cnt[0]),
                    32'(pos_cnt[1] + pos_cnt[2] + pos_cnt[3] + neg_cnt[1] + neg_cnt[2] + neg_cnt[3])}, {32'h11, 32'h0});
        clearCounts();

        // Bounce on ch1: high 3, low 1, high 2, low 1, then stable high
        bounce_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        foreach (bounce_seq[k]) applyStimulus({2'b00, bounce_seq[k][0], 1'b0}, 4'b1111, 1);
        checkOutput("bounce_no_pulse", {32'(pos_cnt[1]), 32'(neg_cnt[1])}, 64'h0);
        applyStimulus(4'b0010, 4'b1111, 5);
        checkOutput("bounce_pre_state", {60'h0, btn_state}, 64'h0);
        tick();
        checkOutput("bounce_pos", {56'h0, btn_state, btn_posedge}, 64'h22);
        applyStimulus(4'b0000, 4'b1111, 10);
        checkOutput("bounce_counts", {32'(pos_cnt[1]), 32'(neg_cnt[1])}, {32'd1, 32'd1});
        clearCounts();

        // Long press and repeat on ch2
        applyStimulus(4'b0100, 4'b1111, 6);
        checkOutput("long_pos", {60'h0, btn_posedge}, 64'h4);
        applyStimulus(4'b0100, 4'b1111, 19);
        checkOutput("long_not_early", {60'h0, btn_long}, 64'h0);
        tick();
        checkOutput("long_at_20", {56'h0, btn_long, btn_repeat}, 64'h40);
        applyStimulus(4'b0100, 4'b1111, 4);
        checkOutput("rep_not_early", {56'h0, btn_long, btn_repeat}, 64'h0);
        tick();
        checkOutput("rep_at_25", {60'h0, btn_repeat}, 64'h4);
        tick();
        applyStimulus(4'b0000, 4'b1111, 4);
        checkOutput("rep_at_30", {60'h0, btn_repeat}, 64'h4);
        applyStimulus(4'b0000, 4'b1111, 2);
        checkOutput("long_release", {56'h0, btn_state, btn_negedge}, 64'h04);
        applyStimulus(4'b0000, 4'b1111, 30);
        checkOutput("long_counts", {16'(pos_cnt[2]), 16'(neg_cnt[2]), 16'(long_cnt[2]), 16'(rep_cnt[2])},
                    {16'd1, 16'd1, 16'd1, 16'd2});
        clearCounts();

        // Release collision on ch3: btn_state falls on the long terminal edge
        applyStimulus(4'b1000, 4'b1111, 6);
        checkOutput("coll_pos", {60'h0, btn_posedge}, 64'h8);
        applyStimulus(4'b1000, 4'b1111, 14);
        applyStimulus(4'b0000, 4'b1111, 6);
        checkOutput("coll_neg_only", {52'h0, btn_state, btn_negedge, btn_long}, 64'h080);
        applyStimulus(4'b0000, 4'b1111, 10);
        checkOutput("coll_no_long", {32'(long_cnt[3]), 32'(rep_cnt[3])}, 64'h0);
        applyStimulus(4'b1000, 4'b1111, 6);
        checkOutput("repress_pos", {60'h0, btn_posedge}, 64'h8);
        applyStimulus(4'b1000, 4'b1111, 19);
        checkOutput("repress_long_not_early", {60'h0, btn_long}, 64'h0);
        tick();
        checkOutput("repress_long_at_20", {60'h0, btn_long}, 64'h8);
        applyStimulus(4'b0000, 4'b1111, 15);
        checkOutput("repress_counts", {16'(long_cnt[3]), 16'(rep_cnt[3]), 16'(neg_cnt[3]), 12'h0, btn_state},
                    {16'd1, 16'd1, 16'd2, 16'h0});
        clearCounts();

        // Active-low instance: pins idle high through everything so far, then press pin 0
        applyStimulus(4'b0000, 4'b1110, 5);
        checkOutput("al_idle_no_pulses", 64'(al_pulses), 64'h0);
        tick();
        checkOutput("al_pos", {56'h0, al_state, al_posedge}, 64'h11);
        tick();
        checkOutput("al_pos_width", {56'h0, al_state, al_posedge}, 64'h10);
        applyStimulus(4'b0000, 4'b1111, 10);
        checkOutput("al_release", {60'h0, al_state}, 64'h0);
        clearCounts();

        // Reset asserted mid-press clears everything at once; no pulse on its release
        applyStimulus(4'b0001, 4'b1111, 8);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_clear", {44'h0, btn_state, btn_posedge, btn_negedge, btn_long, btn_repeat}, 64'h0);
        applyStimulus(4'b0000, 4'b1111, 2);
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b1111, 10);
        checkOutput("midreset_no_neg", {32'(neg_cnt[0]), 28'h0, btn_state}, 64'h0);

        checkOutput("pulse_invariants", 64'(violations), 64'h0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
